// File: rtl/dither_pkg.sv
// rtl/dither_pkg.sv - shared dither sizing helpers, threshold bit-manipulation functions and types
package dither_pkg;

   // Widest dither field the helper functions support.
   localparam int DITHER_MAX_D = 32;

   typedef logic [DITHER_MAX_D-1:0] dither_t;

   // Dither width D from the input/output sample widths.
   function automatic int dither_d(input int in_width, input int out_width);
      return in_width - out_width;
   endfunction

   // Width W of each dither coordinate counter (D/2).
   function automatic int dither_w(input int in_width, input int out_width);
      return (in_width - out_width) / 2;
   endfunction

   // p[2i] = a[i], p[2i+1] = b[i] for i < w; bits above 2w are zero.
   function automatic dither_t interleave(input dither_t a, input dither_t b, input int w);
      dither_t r;
      r = '0;
      for (int i = 0; i < DITHER_MAX_D / 2; i++) begin
         if (i < w) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
         end
      end
      return r;
   endfunction

   // Reverse the low d bits of p; bits above d are zero.
   function automatic dither_t bit_reverse(input dither_t p, input int d);
      dither_t r;
      r = '0;
      for (int i = 0; i < DITHER_MAX_D; i++) begin
         if (i < d) begin
            r[d-1-i] = p[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dither_threshold.sv
// rtl/dither_threshold.sv - combinational ordered-dither threshold from (x, y) coordinates
module dither_threshold
   import dither_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   output logic [2*W-1:0] t
);

   // Interleave (x^y) with y, then reverse so the fastest-changing bit lands in the MSB.
   assign t = (2*W)'(bit_reverse(interleave(dither_t'(x ^ y), dither_t'(y), W), 2*W));

endmodule

// File: rtl/dither_requantizer.sv
// rtl/dither_requantizer.sv - 2-stage dithered requantizer from IN_WIDTH to OUT_WIDTH signed samples
module dither_requantizer
   import dither_pkg::*;
#(
   parameter int IN_WIDTH  = 24,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 dither_en_in,
   input  logic [IN_WIDTH-1:0]  sample_in,
   input  logic                 sample_valid_in,
   output logic                 sample_ready_out,
   output logic [OUT_WIDTH-1:0] sample_out,
   output logic                 sample_valid_out,
   input  logic                 sample_ready_in
);

   localparam int D  = dither_d(IN_WIDTH, OUT_WIDTH);
   localparam int W  = dither_w(IN_WIDTH, OUT_WIDTH);
   // The shifted sum carries exactly one extra bit beyond the output width.
   localparam int QW = OUT_WIDTH + 1;

   localparam logic [D-1:0]         T_HALF = {1'b1, {(D-1){1'b0}}};
   localparam logic signed [QW-1:0] Q_MAX  = $signed({2'b00, {(OUT_WIDTH-1){1'b1}}});

   logic [W-1:0]              x;
   logic [W-1:0]              y;
   logic [D-1:0]              t_dith;
   logic [D-1:0]              t;
   logic                      accept;
   logic                      s1_valid;
   logic                      s1_load;
   logic                      s2_load;
   logic signed [IN_WIDTH:0]  s1_sum;
   logic signed [IN_WIDTH:0]  sum_next;
   logic signed [QW-1:0]      q;
   logic [OUT_WIDTH-1:0]      q_sat;

   dither_threshold #(.W(W)) u_threshold (
      .x (x),
      .y (y),
      .t (t_dith)
   );

   assign s2_load          = !sample_valid_out || sample_ready_in;
   assign s1_load          = !s1_valid || s2_load;
   assign sample_ready_out = s1_load;
   assign accept           = sample_valid_in && s1_load;

   assign t        = dither_en_in ? t_dith : T_HALF;
   assign sum_next = $signed({sample_in[IN_WIDTH-1], sample_in}) + $signed({1'b0, t});

   // Floor division by 2^D, then clamp the positive side only (t >= 0 keeps the negative side in range).
   assign q     = QW'(s1_sum >>> D);
   assign q_sat = (q > Q_MAX) ? Q_MAX[OUT_WIDTH-1:0] : q[OUT_WIDTH-1:0];

   // Dither position advances once per accepted input; y steps when x wraps.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         x <= '0;
         y <= '0;
      end else if (accept) begin
         x <= x + 1'b1;
         if (x == {W{1'b1}}) begin
            y <= y + 1'b1;
         end
      end
   end

   // Stage 1: capture the sample plus its threshold.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
      end else if (s1_load) begin
         s1_valid <= accept;
         if (accept) begin
            s1_sum <= sum_next;
         end
      end
   end

   // Stage 2: shift, saturate and present to the downstream consumer; holds while stalled.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sample_valid_out <= 1'b0;
         sample_out       <= '0;
      end else if (s2_load) begin
         sample_valid_out <= s1_valid;
         if (s1_valid) begin
            sample_out <= q_sat;
         end
      end
   end

endmodule

// File: tb/tb_dither_requantizer.sv
// tb/tb_dither_requantizer.sv - directed self-checking bench for dither_requantizer
module tb_dither_requantizer;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        dither_en_in;
   logic [23:0] sample_in;
   logic        sample_valid_in;
   logic        sample_ready_out;
   logic [15:0] sample_out;
   logic        sample_valid_out;
   logic        sample_ready_in;

   logic [3:0]  tx;
   logic [3:0]  ty;
   logic [7:0]  tt;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          out_cnt;
   int          ones_cnt;
   logic [15:0] last_out;
   logic [15:0] expq[$];
   logic [15:0] exp_val;
   bit          seen[256];
   int          distinct;
   int          sent;
   int          recv;
   bit          prev_stall;
   logic [15:0] prev_out;

   always #5 clk = ~clk;

   dither_requantizer #(.IN_WIDTH(24), .OUT_WIDTH(16)) dut (
      .clk_in           (clk),
      .rst_in           (rst_in),
      .dither_en_in     (dither_en_in),
      .sample_in        (sample_in),
      .sample_valid_in  (sample_valid_in),
      .sample_ready_out (sample_ready_out),
      .sample_out       (sample_out),
      .sample_valid_out (sample_valid_out),
      .sample_ready_in  (sample_ready_in)
   );

   dither_threshold #(.W(4)) thr (
      .x (tx),
      .y (ty),
      .t (tt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_in          = 1'b1;
      sample_valid_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_in = 1'b0;
   endtask

   // Continuous stream of n equal samples with downstream always ready; tallies outputs.
   task automatic run_stream(input logic [23:0] val, input logic en, input int n);
      out_cnt         = 0;
      ones_cnt        = 0;
      sample_ready_in = 1'b1;
      dither_en_in    = en;
      sample_in       = val;
      for (int i = 0; i < n + 3; i++) begin
         @(negedge clk);
         if (sample_valid_out) begin
            out_cnt++;
            if (sample_out == 16'h0001) ones_cnt++;
            last_out = sample_out;
         end
         sample_valid_in = (i < n);
      end
      sample_valid_in = 1'b0;
   endtask

   function automatic logic [23:0] ramp(input int k);
      return 24'(-4000000 + k * 8123);
   endfunction

   // Reference: threshold from position k written arithmetically, then floor and clamp.
   function automatic logic [15:0] model(input int k, input logic signed [23:0] s);
      int     x;
      int     y;
      int     t;
      longint v;
      x = k % 16;
      y = (k / 16) % 16;
      t = 0;
      for (int i = 0; i < 4; i++) begin
         t += (((x ^ y) >> i) & 1) * (1 << (7 - 2*i));
         t += ((y >> i) & 1) * (1 << (6 - 2*i));
      end
      v = longint'(s) + longint'(t);
      v = v >>> 8;
      if (v > 32767) v = 32767;
      return v[15:0];
   endfunction

   initial begin
      rst_in          = 1'b1;
      dither_en_in    = 1'b0;
      sample_in       = '0;
      sample_valid_in = 1'b0;
      sample_ready_in = 1'b1;
      last_out        = '0;

      // Threshold map corners and full sweep
      tx = 4'd0; ty = 4'd0; #1;
      check("thr_x0_y0", tt, 8'd0);
      tx = 4'd1; ty = 4'd0; #1;
      check("thr_x1_y0", tt, 8'd128);
      tx = 4'd0; ty = 4'd1; #1;
      check("thr_x0_y1", tt, 8'd192);
      distinct = 0;
      for (int i = 0; i < 256; i++) begin
         tx = 4'(i % 16);
         ty = 4'(i / 16);
         #1;
         if (!seen[tt]) distinct++;
         seen[tt] = 1'b1;
      end
      check("thr_sweep_distinct", distinct, 256);

      // Reset state
      do_reset();
      check("rst_valid_out", sample_valid_out, 1'b0);
      check("rst_sample_out", sample_out, 16'h0000);
      check("rst_ready_out", sample_ready_out, 1'b1);

      // Dither off: round-half-up and two-cycle latency
      dither_en_in    = 1'b0;
      sample_in       = 24'h000180;
      sample_valid_in = 1'b1;
      @(negedge clk);
      sample_valid_in = 1'b0;
      check("lat_n1_valid", sample_valid_out, 1'b0);
      @(negedge clk);
      check("lat_n2_valid", sample_valid_out, 1'b1);
      check("round_0x180", sample_out, 16'h0002);
      run_stream(24'h00017F, 1'b0, 1);
      check("round_0x17f", last_out, 16'h0001);
      run_stream(24'h7FFFFF, 1'b0, 1);
      check("sat_pos", last_out, 16'h7FFF);

      // Dither on: 256 samples of 0x40 from reset, then reach t=255 for the minimum input
      do_reset();
      run_stream(24'h000040, 1'b1, 256);
      check("dith_count", out_cnt, 256);
      check("dith_ones", ones_cnt, 64);
      run_stream(24'h000000, 1'b1, 240);
      check("zeros_count", out_cnt, 240);
      check("zeros_ones", ones_cnt, 0);
      run_stream(24'h800000, 1'b1, 1);
      check("sat_neg_t255", last_out, 16'h8000);

      // Reset with both stages full
      do_reset();
      sample_ready_in = 1'b0;
      dither_en_in    = 1'b1;
      sample_in       = 24'h123456;
      sample_valid_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("full_ready_out", sample_ready_out, 1'b0);
      check("full_valid_out", sample_valid_out, 1'b1);
      rst_in          = 1'b1;
      sample_valid_in = 1'b0;
      @(negedge clk);
      check("midrst_valid_out", sample_valid_out, 1'b0);
      rst_in = 1'b0;
      run_stream(24'h0000FF, 1'b1, 1);
      check("midrst_t0", last_out, 16'h0000);
      run_stream(24'h0000FF, 1'b1, 1);
      check("midrst_t128", last_out, 16'h0001);

      // Random backpressure against the reference model
      do_reset();
      dither_en_in = 1'b1;
      expq.delete();
      sent       = 0;
      recv       = 0;
      prev_stall = 1'b0;
      prev_out   = '0;
      for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            check("stall_valid", sample_valid_out, 1'b1);
            check("stall_data", sample_out, prev_out);
         end
         sample_ready_in = 1'($urandom_range(0, 1));
         sample_valid_in = (sent < 1000) && ($urandom_range(0, 3) != 0);
         sample_in       = ramp(sent);
         #1;
         if (sample_valid_out && sample_ready_in) begin
            check("bp_not_extra", expq.size() != 0, 1'b1);
            if (expq.size() != 0) begin
               exp_val = expq.pop_front();
               check("bp_data", sample_out, exp_val);
            end
            recv++;
         end
         if (sample_valid_in && sample_ready_out) begin
            expq.push_back(model(sent, ramp(sent)));
            sent++;
         end
         prev_stall = sample_valid_out && !sample_ready_in;
         prev_out   = sample_out;
      end
      sample_valid_in = 1'b0;
      check("bp_recv_count", recv, 1000);
      check("bp_queue_empty", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
